// File: rtl/param_node_pkg.sv
// Shared fixed-point format, activation codes and FSM state type for the
// sequential neural-network node family.
package param_node_pkg;

  localparam int N = 32;
  localparam int F = 24;
  localparam int I = 8;

  typedef enum logic [1:0] {
    ACT_RELU = 2'd0,
    ACT_LIN  = 2'd1,
    ACT_ID   = 2'd2,
    ACT_HSIG = 2'd3
  } act_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_ACT  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic signed [N-1:0] ONE      = N'(1 << F);
  localparam logic signed [N-1:0] HALF     = N'(1 << (F - 1));
  localparam logic signed [N-1:0] TWO      = N'(2 << F);
  localparam logic signed [N-1:0] TWO_HALF = N'(5 << (F - 1));
  localparam logic signed [N-1:0] SAT_MAX  = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] SAT_MIN  = {1'b1, {(N-1){1'b0}}};

endpackage

// File: rtl/param_node_act.sv
// Combinational activation stage: maps a Q(I).(F) pre-activation value to
// the selected activation output. Shared by other node variants.
module node_act
  import param_node_pkg::*;
(
  input  logic [1:0]          i_act_sel,
  input  logic signed [N-1:0] i_z,
  output logic signed [N-1:0] o_y
);

  always_comb begin
    o_y = i_z;
    case (i_act_sel)
      ACT_RELU: begin
        if (i_z < 0) o_y = '0;
      end
      ACT_LIN: begin
        if (i_z >= TWO)    o_y = ONE;
        else if (i_z <= 0) o_y = '0;
        else               o_y = i_z >>> 1;
      end
      ACT_HSIG: begin
        if (i_z >= TWO_HALF)       o_y = ONE;
        else if (i_z <= -TWO_HALF) o_y = '0;
        else                       o_y = HALF + (i_z >>> 2);
      end
      default: o_y = i_z;
    endcase
  end

endmodule

// File: rtl/param_node.sv
// Sequential neural-network node: y = act(sum(x[j]*w[j]) + b), SX products
// time-multiplexed over LANES multipliers, with valid/ready on both sides.
module param_node
  import param_node_pkg::*;
#(
  parameter int SX    = 2,
  parameter int LANES = 1,
  parameter int SAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*SX-1:0]   nx,
  input  logic [N*SX-1:0]   nw,
  input  logic [N-1:0]      b,
  input  logic [1:0]        act_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      y,
  output logic [N-1:0]      z,
  output logic              ovf
);

  // state | meaning
  // IDLE  | waiting for an input transaction
  // MAC   | accumulating one LANES-wide chunk per cycle
  // ACT   | rounding/saturation and activation, result registered
  // DONE  | result presented until out_ready

  localparam int K  = (SX + LANES - 1) / LANES;
  localparam int PW = N * LANES * K;
  localparam int AW = 2*N + $clog2(SX + 1);
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int ZH = 2*F + I;

  state_e                r_state, w_state_nxt;
  logic [PW-1:0]         r_x, r_w;
  logic [CW-1:0]         r_cnt;
  logic [1:0]            r_act_sel;
  logic signed [AW-1:0]  r_acc, w_mac_sum;
  logic signed [2*N-1:0] w_prod [LANES];
  logic [N-1:0]          r_y, r_z;
  logic                  r_ovf;
  logic                  w_accept, w_ovf;
  logic [AW-ZH:0]        w_hi;
  logic signed [N-1:0]   w_z, w_y;

  assign w_accept = (r_state == ST_IDLE) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_state_nxt = ST_MAC;
      ST_MAC:  if (r_cnt == '0) w_state_nxt = ST_ACT;
      ST_ACT:  w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operands are zero-padded to K full chunks so unused lanes multiply by 0.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_prod[l] = $signed(r_x[l*N +: N]) * $signed(r_w[l*N +: N]);
    end
  end

  always_comb begin
    w_mac_sum = r_acc;
    for (int l = 0; l < LANES; l++) begin
      w_mac_sum = w_mac_sum + AW'(w_prod[l]);
    end
  end

  // Result fits N bits only if everything above the kept window is sign extension.
  assign w_hi  = r_acc[AW-1:ZH-1];
  assign w_ovf = !((&w_hi) || !(|w_hi));

  always_comb begin
    w_z = r_acc[ZH-1:F];
    if ((SAT != 0) && w_ovf) w_z = r_acc[AW-1] ? SAT_MIN : SAT_MAX;
  end

  node_act u_act (
    .i_act_sel (r_act_sel),
    .i_z       (w_z),
    .o_y       (w_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x       <= '0;
      r_w       <= '0;
      r_cnt     <= '0;
      r_act_sel <= '0;
      r_acc     <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_x       <= PW'(nx);
      r_w       <= PW'(nw);
      r_act_sel <= act_sel;
      r_acc     <= {{(AW-N-F){b[N-1]}}, b, {F{1'b0}}};
      r_cnt     <= CW'(K - 1);
    end else if (r_state == ST_MAC) begin
      r_acc <= w_mac_sum;
      r_x   <= r_x >> (N*LANES);
      r_w   <= r_w >> (N*LANES);
      r_cnt <= r_cnt - CW'(1);
    end else if (r_state == ST_ACT) begin
      r_z   <= w_z;
      r_y   <= w_y;
      r_ovf <= w_ovf;
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign y         = r_y;
  assign z         = r_z;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_param_node.sv
// Randomized bench for param_node against an arithmetic reference model:
// two SX=2 nodes (saturating and wrapping) share one bus, plus an SX=5/LANES=2 node.
module tb_param_node;

  localparam int ONE_I = 1 << 24;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        ab_in_valid, ab_out_ready;
  logic [63:0] ab_nx, ab_nw;
  logic [31:0] ab_b;
  logic [1:0]  ab_sel;
  logic        a_in_ready, a_out_valid, a_ovf;
  logic [31:0] a_y, a_z;
  logic        b_in_ready, b_out_valid, b_ovf;
  logic [31:0] b_y, b_z;

  logic         c_in_valid, c_out_ready;
  logic [159:0] c_nx, c_nw;
  logic [31:0]  c_b;
  logic [1:0]   c_sel;
  logic         c_in_ready, c_out_valid, c_ovf;
  logic [31:0]  c_y, c_z;

  param_node #(.SX(2), .LANES(1), .SAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(ab_in_valid), .in_ready(a_in_ready),
    .nx(ab_nx), .nw(ab_nw), .b(ab_b), .act_sel(ab_sel),
    .out_valid(a_out_valid), .out_ready(ab_out_ready), .y(a_y), .z(a_z), .ovf(a_ovf));

  param_node #(.SX(2), .LANES(1), .SAT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(ab_in_valid), .in_ready(b_in_ready),
    .nx(ab_nx), .nw(ab_nw), .b(ab_b), .act_sel(ab_sel),
    .out_valid(b_out_valid), .out_ready(ab_out_ready), .y(b_y), .z(b_z), .ovf(b_ovf));

  param_node #(.SX(5), .LANES(2), .SAT(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .nx(c_nx), .nw(c_nw), .b(c_b), .act_sel(c_sel),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .y(c_y), .z(c_z), .ovf(c_ovf));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Exact sum in wide arithmetic, floor to Q8.24, then range handling and activation.
  function automatic void ref_node(input logic [159:0] px, input logic [159:0] pw, input int sx,
                                   input logic [31:0] bb, input logic [1:0] sel, input bit sat,
                                   output logic [31:0] ez, output logic [31:0] ey, output logic eovf);
    logic signed [127:0] tot, zq;
    logic [31:0] xj, wj;
    int zs, ys;
    tot = $signed({{96{bb[31]}}, bb}) * 128'sd16777216;
    for (int j = 0; j < sx; j++) begin
      xj  = px[j*32 +: 32];
      wj  = pw[j*32 +: 32];
      tot = tot + $signed({{96{xj[31]}}, xj}) * $signed({{96{wj[31]}}, wj});
    end
    zq   = tot >>> 24;
    eovf = 1'b0;
    ez   = zq[31:0];
    if (zq > 128'sd2147483647) begin
      eovf = 1'b1;
      if (sat) ez = 32'h7FFF_FFFF;
    end else if (zq < -128'sd2147483648) begin
      eovf = 1'b1;
      if (sat) ez = 32'h8000_0000;
    end
    zs = $signed(ez);
    case (sel)
      2'd0:    ys = (zs < 0) ? 0 : zs;
      2'd1:    ys = (zs >= 2*ONE_I) ? ONE_I : ((zs <= 0) ? 0 : (zs >>> 1));
      2'd2:    ys = zs;
      default: ys = (zs >= 5*ONE_I/2) ? ONE_I : ((zs <= -5*ONE_I/2) ? 0 : (ONE_I/2 + (zs >>> 2)));
    endcase
    ey = ys;
  endfunction

  function automatic logic [31:0] rnd_q(input bit big);
    logic [31:0] r;
    if (big) r = $urandom;
    else     r = $urandom_range(32'h0800_0000) - 32'h0400_0000;
    return r;
  endfunction

  // Called at #1 after an edge with both SX=2 nodes idle; returns with them in DONE.
  task automatic run_ab(input logic [63:0] x, input logic [63:0] w, input logic [31:0] bb,
                        input logic [1:0] sel, input string tag);
    int cyc;
    logic [31:0] ez, ey;
    logic eo;
    ab_nx = x; ab_nw = w; ab_b = bb; ab_sel = sel; ab_in_valid = 1'b1;
    check({tag, "_in_ready"}, a_in_ready, 1);
    @(posedge clk); #1;
    ab_in_valid = 1'b0;
    ab_nx = {$urandom, $urandom}; ab_nw = {$urandom, $urandom};
    ab_b = $urandom; ab_sel = 2'($urandom);
    cyc = 1;
    while (!a_out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, cyc, 4);
    check({tag, "_b_valid"}, b_out_valid, 1);
    ref_node(160'(x), 160'(w), 2, bb, sel, 1'b1, ez, ey, eo);
    check({tag, "_a_z"}, a_z, ez);
    check({tag, "_a_y"}, a_y, ey);
    check({tag, "_a_ovf"}, a_ovf, eo);
    ref_node(160'(x), 160'(w), 2, bb, sel, 1'b0, ez, ey, eo);
    check({tag, "_b_z"}, b_z, ez);
    check({tag, "_b_y"}, b_y, ey);
    check({tag, "_b_ovf"}, b_ovf, eo);
  endtask

  task automatic release_ab(input string tag);
    ab_out_ready = 1'b1;
    @(posedge clk); #1;
    ab_out_ready = 1'b0;
    check({tag, "_rel_valid"}, a_out_valid, 0);
    check({tag, "_rel_ready"}, a_in_ready, 1);
  endtask

  task automatic run_c(input logic [159:0] x, input logic [159:0] w, input logic [31:0] bb,
                       input logic [1:0] sel, input string tag);
    int cyc;
    logic [31:0] ez, ey;
    logic eo;
    c_nx = x; c_nw = w; c_b = bb; c_sel = sel; c_in_valid = 1'b1;
    check({tag, "_in_ready"}, c_in_ready, 1);
    @(posedge clk); #1;
    c_in_valid = 1'b0;
    c_nx = '0; c_nw = '0; c_b = $urandom;
    cyc = 1;
    while (!c_out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, cyc, 5);
    ref_node(x, w, 5, bb, sel, 1'b1, ez, ey, eo);
    check({tag, "_z"}, c_z, ez);
    check({tag, "_y"}, c_y, ey);
    check({tag, "_ovf"}, c_ovf, eo);
    c_out_ready = 1'b1;
    @(posedge clk); #1;
    c_out_ready = 1'b0;
    check({tag, "_rel_valid"}, c_out_valid, 0);
  endtask

  initial begin
    logic [159:0] cx, cw;
    rst_n = 1'b0;
    ab_in_valid = 1'b0; ab_out_ready = 1'b0; ab_nx = '0; ab_nw = '0; ab_b = '0; ab_sel = '0;
    c_in_valid = 1'b0; c_out_ready = 1'b0; c_nx = '0; c_nw = '0; c_b = '0; c_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", a_out_valid, 0);
    check("rst_z", a_z, 0);
    check("rst_y", a_y, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_c_out_valid", c_out_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", a_in_ready, 1);
    check("rst_c_in_ready", c_in_ready, 1);

    run_ab({32'hFE00_0000, 32'h0180_0000}, {32'h0080_0000, 32'h0200_0000}, 32'h0040_0000, 2'd0, "t1");
    check("t1_const_z", a_z, 32'h0240_0000);
    check("t1_const_y", a_y, 32'h0240_0000);
    release_ab("t1");

    run_ab({32'h0100_0000, 32'h0100_0000}, {32'hFE00_0000, 32'hFF00_0000}, 32'h0, 2'd0, "t2");
    check("t2_const_z", a_z, 32'hFD00_0000);
    check("t2_const_y", a_y, 32'h0);
    release_ab("t2");

    run_ab({32'h6400_0000, 32'h6400_0000}, {32'h0100_0000, 32'h0100_0000}, 32'h0, 2'd2, "t3");
    check("t3_sat_z", a_z, 32'h7FFF_FFFF);
    check("t3_sat_ovf", a_ovf, 1);
    check("t3_wrap_z", b_z, 32'hC800_0000);
    check("t3_wrap_ovf", b_ovf, 1);
    release_ab("t3");

    run_ab({32'h0, 32'h0100_0000}, {32'h0, 32'h0100_0000}, 32'h0, 2'd1, "t4a");
    check("t4a_lin1", a_y, 32'h0080_0000);
    release_ab("t4a");
    run_ab({32'h0100_0000, 32'h0100_0000}, {32'h0200_0000, 32'h0100_0000}, 32'h0, 2'd1, "t4b");
    check("t4b_lin3", a_y, 32'h0100_0000);
    release_ab("t4b");
    run_ab({32'h0100_0000, 32'h0100_0000}, {32'hFE00_0000, 32'hFF00_0000}, 32'h0, 2'd3, "t4c");
    check("t4c_hsig_m3", a_y, 32'h0);
    release_ab("t4c");
    run_ab({32'h0, 32'h0100_0000}, {32'h0, 32'h0100_0000}, 32'h0, 2'd3, "t4d");
    check("t4d_hsig_1", a_y, 32'h00C0_0000);

    // New request offered while DONE is being released must not be taken that cycle.
    ab_nx = '0; ab_nw = '0; ab_b = '0; ab_in_valid = 1'b1; ab_out_ready = 1'b1;
    @(posedge clk); #1;
    ab_out_ready = 1'b0;
    check("done_no_accept", a_in_ready, 1);

    for (int t = 0; t < 40; t++) begin
      bit big;
      int hold;
      big = ($urandom_range(3) == 0);
      run_ab({rnd_q(big), rnd_q(big)}, {rnd_q(big), rnd_q(big)}, rnd_q(big), 2'($urandom), "rnd");
      hold = $urandom_range(3);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check("rnd_hold_valid", a_out_valid, 1);
        check("rnd_hold_ready", a_in_ready, 0);
      end
      release_ab("rnd");
    end

    cx = {32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000};
    cw = {32'h0500_0000, 32'h0400_0000, 32'h0300_0000, 32'h0200_0000, 32'h0100_0000};
    run_c(cx, cw, 32'hFF00_0000, 2'd2, "t5");
    for (int t = 0; t < 15; t++) begin
      bit big;
      big = ($urandom_range(3) == 0);
      for (int j = 0; j < 5; j++) begin
        cx[j*32 +: 32] = rnd_q(big);
        cw[j*32 +: 32] = rnd_q(big);
      end
      run_c(cx, cw, rnd_q(big), 2'($urandom), "rnd_c");
    end

    run_ab({32'hFE00_0000, 32'h0180_0000}, {32'h0080_0000, 32'h0200_0000}, 32'h0040_0000, 2'd0, "t6");
    for (int h = 0; h < 8; h++) begin
      @(posedge clk); #1;
      check("t6_hold_z", a_z, 32'h0240_0000);
      check("t6_hold_y", a_y, 32'h0240_0000);
      check("t6_hold_ovf", a_ovf, 0);
      check("t6_hold_valid", a_out_valid, 1);
      check("t6_hold_in_ready", a_in_ready, 0);
    end
    release_ab("t6");

    ab_nx = {32'h0100_0000, 32'h0100_0000}; ab_nw = {32'h0100_0000, 32'h0100_0000};
    ab_b = 32'h0; ab_sel = 2'd2; ab_in_valid = 1'b1;
    @(posedge clk); #1;
    ab_in_valid = 1'b0;
    check("t6_mac_busy", a_in_ready, 0);
    rst_n = 1'b0;
    #2;
    check("t6_rst_valid", a_out_valid, 0);
    check("t6_rst_z", a_z, 0);
    check("t6_rst_y", a_y, 0);
    check("t6_rst_ovf", a_ovf, 0);
    check("t6_rst_b_z", b_z, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_rel_in_ready", a_in_ready, 1);
    for (int h = 0; h < 6; h++) begin
      @(posedge clk); #1;
      check("t6_no_stale", a_out_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
